mem_byte_bridge: RTL and testbench

Sequential data-memory bridge directly downstream of the single-cycle CPU core. It takes the core's load/store request (address from the ALU, size-adjusted store data, width from funct3) and performs it as a sequence of single-byte transfers on a narrow req/ack external memory bus. It holds `stall` high so the core's PC/register writes are frozen until the access finishes, then returns raw little-endian load data for the core's load length changer to sign/zero-extend.

---
 rtl/mem_byte_bridge.sv | 176 +++++++++++++++++
 tb/tb_mem_byte_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_bridge.sv
// Byte-serial load/store bridge between the CPU core and a narrow req/ack memory bus.
// Define MEM_BYTE_BRIDGE_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error completions.
module mem_byte_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err,
   output logic [31:0] ext_addr,
   output logic [7:0]  ext_wdata,
   output logic        ext_we,
   output logic        ext_req,
   input  logic        ext_ack,
   input  logic [7:0]  ext_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wbuf_q, wbuf_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] ext_addr_q, ext_addr_d;
   logic [2:0]  nbytes_q, nbytes_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  wait_q, wait_d;
   logic [7:0]  ext_wdata_q, ext_wdata_d;
   logic        ext_we_q, ext_we_d;
   logic        ext_req_q, ext_req_d;
   logic        err_q, err_d;
   logic [2:0]  req_nbytes;
   logic [2:0]  idx_next;
   logic        bad_req;
   logic        unused_funct3;

   // funct3[2] only selects sign extension, which the core handles after us.
   assign unused_funct3 = funct3[2];

   always_comb begin
      req_nbytes = 3'd4;
      case (funct3[1:0])
         2'b00:   req_nbytes = 3'd1;
         2'b01:   req_nbytes = 3'd2;
         default: req_nbytes = 3'd4;
      endcase
      bad_req = (funct3[1:0] == 2'b11);
`ifdef MEM_BYTE_BRIDGE_MISALIGN_TRAP_EN
      if ((funct3[1:0] == 2'b01 && addr[0]) ||
          (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)) begin
         bad_req = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      wbuf_d      = wbuf_q;
      rdata_d     = rdata_q;
      ext_addr_d  = ext_addr_q;
      nbytes_d    = nbytes_q;
      idx_d       = idx_q;
      wait_d      = wait_q;
      ext_wdata_d = ext_wdata_q;
      ext_we_d    = ext_we_q;
      ext_req_d   = ext_req_q;
      err_d       = 1'b0;
      idx_next    = idx_q + 3'd1;

      case (state_q)
         IDLE: begin
            if (load || store) begin
               base_d   = addr;
               wbuf_d   = wdata;
               nbytes_d = req_nbytes;
               idx_d    = 3'd0;
               wait_d   = 8'd0;
               rdata_d  = 32'd0;
               if (bad_req) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d     = REQ;
                  ext_req_d   = 1'b1;
                  ext_we_d    = store;
                  ext_addr_d  = addr;
                  ext_wdata_d = wdata[7:0];
               end
            end
         end

         REQ: begin
            if (ext_ack) begin
               if (!ext_we_q) begin
                  rdata_d[{idx_q[1:0], 3'b000} +: 8] = ext_rdata;
               end
               idx_d  = idx_next;
               wait_d = 8'd0;
               if (idx_next == nbytes_q) begin
                  state_d   = DONE;
                  ext_req_d = 1'b0;
                  ext_we_d  = 1'b0;
               end else begin
                  ext_addr_d  = base_q + {29'd0, idx_next};
                  ext_wdata_d = wbuf_q[{idx_next[1:0], 3'b000} +: 8];
               end
            end else if (wait_q + 8'd1 == TIMEOUT_C) begin
               // Abort; bytes never received stay zero in rdata.
               state_d   = DONE;
               err_d     = 1'b1;
               wait_d    = 8'd0;
               ext_req_d = 1'b0;
               ext_we_d  = 1'b0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            ext_req_d = 1'b0;
            ext_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         base_q      <= 32'd0;
         wbuf_q      <= 32'd0;
         rdata_q     <= 32'd0;
         ext_addr_q  <= 32'd0;
         nbytes_q    <= 3'd0;
         idx_q       <= 3'd0;
         wait_q      <= 8'd0;
         ext_wdata_q <= 8'd0;
         ext_we_q    <= 1'b0;
         ext_req_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         wbuf_q      <= wbuf_d;
         rdata_q     <= rdata_d;
         ext_addr_q  <= ext_addr_d;
         nbytes_q    <= nbytes_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         ext_wdata_q <= ext_wdata_d;
         ext_we_q    <= ext_we_d;
         ext_req_q   <= ext_req_d;
         err_q       <= err_d;
      end
   end

   assign stall     = (load || store) && (state_q != DONE);
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign ext_addr  = ext_addr_q;
   assign ext_wdata = ext_wdata_q;
   assign ext_we    = ext_we_q;
   assign ext_req   = ext_req_q;
endmodule

// File: tb/tb_mem_byte_bridge.sv
// Scoreboard bench for mem_byte_bridge: a byte-addressed memory model answers the bus,
// and a transaction-level model predicts rdata, err and stall length per access.
module tb_mem_byte_bridge;
   localparam int TOUT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata;
   logic        load, store;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic        stall, err;
   logic [31:0] ext_addr;
   logic [7:0]  ext_wdata;
   logic        ext_we, ext_req, ext_ack;
   logic [7:0]  ext_rdata;

   always #5 clock = ~clock;

   mem_byte_bridge #(.TIMEOUT(TOUT)) dut (
      .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
      .load(load), .store(store), .funct3(funct3),
      .rdata(rdata), .stall(stall), .err(err),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we),
      .ext_req(ext_req), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
   );

   typedef struct { logic [31:0] rdata; logic err; int stall_cycles; } exp_t;
   typedef struct { logic [31:0] addr; logic we; logic [7:0] wdata; } bus_t;

   exp_t        exp_q[$];
   bus_t        bus_q[$];
   int          resp_q[$];
   logic [7:0]  mem [logic [31:0]];
   int          tests = 0;
   int          fails = 0;
   int          acks_left = 0;
   bit          bus_allowed = 1'b0;
   bit          done_flag = 1'b0;
   logic [31:0] last_rdata;
   logic        last_err;
   int          last_stall;
   int          stall_cnt = 0;
   int          wait_left = -1;
   exp_t        mon_e;
   bus_t        rsp_b;

   function automatic logic [7:0] mem_rd(logic [31:0] a);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      return mem[a];
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic finishRun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   // Predicts the whole access from size/direction/ack schedule, then drives it and waits for DONE.
   task automatic applyStimulus(bit is_store, bit is_load, logic [31:0] a, logic [31:0] wd,
                                logic [2:0] f3, int min_wait, int max_wait, int n_ack);
      int   n, w;
      bit   bad;
      exp_t e;
      bus_t b;
      n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      bad = (f3[1:0] == 2'b11);
`ifdef MEM_BYTE_BRIDGE_MISALIGN_TRAP_EN
      if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) bad = 1'b1;
`endif
      e.rdata = 32'd0;
      e.err = 1'b0;
      e.stall_cycles = 1;
      if (bad) begin
         e.err = 1'b1;
         bus_allowed = 1'b0;
         acks_left = 0;
      end else begin
         bus_allowed = 1'b1;
         if (n_ack > n) n_ack = n;
         acks_left = n_ack;
         for (int i = 0; i < n_ack; i++) begin
            w = $urandom_range(max_wait, min_wait);
            resp_q.push_back(w);
            e.stall_cycles += w + 1;
            b.addr  = a + 32'(i);
            b.we    = is_store;
            b.wdata = wd[8*i +: 8];
            bus_q.push_back(b);
            if (!is_store) e.rdata[8*i +: 8] = mem_rd(a + 32'(i));
         end
         if (n_ack < n) begin
            e.err = 1'b1;
            e.stall_cycles += TOUT;
         end
      end
      exp_q.push_back(e);

      done_flag = 1'b0;
      load = is_load; store = is_store; addr = a; wdata = wd; funct3 = f3;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clock);
         if (done_flag) break;
      end
      #1;
      if (!done_flag) begin
         tests++; fails++;
         $display("[TB] FAIL done_timeout: actual no DONE required DONE within 1000 cycles");
         finishRun();
      end
      load = 1'b0; store = 1'b0;
   endtask

   // Monitor: a held request with stall low means the bridge is in DONE.
   always @(negedge clock) begin
      if (reset) begin
         stall_cnt = 0;
      end else if ((load || store) && !stall) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL unexpected_done: actual completion required none");
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("rdata", rdata, mon_e.rdata);
            checkOutput("err_done", 32'(err), 32'(mon_e.err));
            checkOutput("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall_cycles));
            checkOutput("ext_req_done", 32'(ext_req), 32'd0);
         end
         last_rdata = rdata; last_err = err; last_stall = stall_cnt;
         done_flag = 1'b1;
         stall_cnt = 0;
      end else begin
         if (stall) stall_cnt++;
         checkOutput("err_outside_done", 32'(err), 32'd0);
      end
   end

   // Bus responder: acks each byte after its scheduled wait and checks the presented byte.
   initial begin
      ext_ack = 1'b0;
      ext_rdata = 8'd0;
      forever begin
         @(posedge clock); #1;
         ext_ack = 1'b0;
         if (!ext_req) begin
            wait_left = -1;
         end else begin
            checkOutput("bus_allowed", 32'd1, 32'(bus_allowed));
            if (wait_left < 0 && acks_left > 0 && resp_q.size() > 0) wait_left = resp_q.pop_front();
            if (wait_left == 0) begin
               if (bus_q.size() == 0) begin
                  tests++; fails++;
                  $display("[TB] FAIL bus_extra: actual byte at 0x%0h required none", ext_addr);
               end else begin
                  rsp_b = bus_q.pop_front();
                  checkOutput("ext_addr", ext_addr, rsp_b.addr);
                  checkOutput("ext_we", 32'(ext_we), 32'(rsp_b.we));
                  checkOutput("ext_wdata", 32'(ext_wdata), 32'(rsp_b.wdata));
               end
               if (ext_we) mem[ext_addr] = ext_wdata;
               else ext_rdata = mem_rd(ext_addr);
               ext_ack = 1'b1;
               acks_left--;
               wait_left = -1;
            end else if (wait_left > 0) begin
               wait_left--;
            end
         end
      end
   end

   initial begin
      bit          ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          nack;
      bus_t        b;

      reset = 1'b1; load = 1'b0; store = 1'b0; addr = 32'd0; wdata = 32'd0; funct3 = 3'd0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_rdata", rdata, 32'd0);
      checkOutput("reset_ext_addr", ext_addr, 32'd0);
      checkOutput("reset_ext_wdata", 32'(ext_wdata), 32'd0);
      checkOutput("reset_ext_we", 32'(ext_we), 32'd0);
      checkOutput("reset_ext_req", 32'(ext_req), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      reset = 1'b0;

      mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
      applyStimulus(1'b0, 1'b1, 32'h100, 32'd0, 3'b010, 0, 0, 4);
      checkOutput("word_load_rdata", last_rdata, 32'h44332211);
      checkOutput("word_load_stall", 32'(last_stall), 32'd5);

      applyStimulus(1'b1, 1'b0, 32'h2002, 32'hAABBCCDD, 3'b001, 2, 2, 4);
      checkOutput("half_store_stall", 32'(last_stall), 32'd7);
      checkOutput("half_store_b0", 32'(mem[32'h2002]), 32'hDD);
      checkOutput("half_store_b1", 32'(mem[32'h2003]), 32'hCC);

      applyStimulus(1'b0, 1'b1, 32'h500, 32'd0, 3'b100, 0, 0, 0);
      checkOutput("timeout_err", 32'(last_err), 32'd1);
      checkOutput("timeout_rdata", last_rdata, 32'd0);
      checkOutput("timeout_stall", 32'(last_stall), 32'(1 + TOUT));

      applyStimulus(1'b0, 1'b1, 32'h101, 32'd0, 3'b010, 0, 1, 4);

      // Reset during the second byte of a word store.
      bus_allowed = 1'b1; acks_left = 2;
      resp_q.push_back(0); resp_q.push_back(0);
      for (int i = 0; i < 2; i++) begin
         b.addr = 32'h300 + 32'(i); b.we = 1'b1; b.wdata = 8'(8'h04 - 8'(i));
         bus_q.push_back(b);
      end
      store = 1'b1; addr = 32'h300; wdata = 32'h01020304; funct3 = 3'b010;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1; store = 1'b0;
      @(posedge clock); #1;
      checkOutput("midreset_ext_req", 32'(ext_req), 32'd0);
      checkOutput("midreset_err", 32'(err), 32'd0);
      checkOutput("midreset_rdata", rdata, 32'd0);
      reset = 1'b0;
      exp_q.delete(); bus_q.delete(); resp_q.delete(); acks_left = 0;
      @(posedge clock); #1;
      checkOutput("after_reset_ext_req", 32'(ext_req), 32'd0);

      applyStimulus(1'b0, 1'b1, 32'h40, 32'd0, 3'b011, 0, 0, 4);
      checkOutput("illegal_err", 32'(last_err), 32'd1);
      checkOutput("illegal_stall", 32'(last_stall), 32'd1);

      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 32'h5566_7788, 3'b010, 0, 2, 4);
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd0, 3'b010, 0, 2, 4);

      for (int t = 0; t < 60; t++) begin
         f3 = 3'($urandom);
         if ($urandom_range(3, 0) != 0 && f3[1:0] == 2'b11) f3[1:0] = 2'b10;
         ld = 1'($urandom_range(1, 0));
         st = 1'($urandom_range(1, 0));
         if (!ld && !st) ld = 1'b1;
         a = (t % 8 == 0) ? 32'h0000_1000 + 32'($urandom_range(7, 0)) : $urandom;
         nack = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : 4;
         applyStimulus(st, ld, a, $urandom, f3, 0, 3, nack);
         repeat ($urandom_range(1, 0)) begin
            @(posedge clock); #1;
         end
      end

      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      finishRun();
   end
endmodule
